if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/REDIRECT fetch FSM.
// Optional macro FETCH_FLUSH_EN squashes the IF/ID slot and raises flush requests on a taken branch.
module if_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        mem_branch,
   input  logic [31:0] mem_pc,
   input  logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic [3:0]  ID_ins_type,
   output logic [3:0]  ID_ins_number
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 4;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   id_pc_q, id_pc_d;
   logic [XLEN-1:0]   id_inst_q, id_inst_d;
   logic              id_valid_q, id_valid_d;
   logic [TAG_W-1:0]  type_q, type_d;
   logic [TAG_W-1:0]  num_q, num_d;
   logic [TAG_W-1:0]  seq_q, seq_d;
   logic              load_c;

   // Class code of an instruction word, derived from its opcode field.
   function automatic logic [TAG_W-1:0] ins_class(input logic [XLEN-1:0] inst);
      logic [5:0] op;
      op = inst[31:26];
      if (inst == '0)               return TAG_W'(0);
      else if (op == 6'h00)         return TAG_W'(1);
      else if (op == 6'h23)         return TAG_W'(2);
      else if (op == 6'h2B)         return TAG_W'(3);
      else if (op == 6'h04)         return TAG_W'(4);
      else if (op == 6'h05)         return TAG_W'(5);
      else if (op[5:3] == 3'b001)   return TAG_W'(6);
      else if (op == 6'h02)         return TAG_W'(7);
      else                          return TAG_W'(15);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= '0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
         type_q     <= '0;
         num_q      <= '0;
         seq_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         type_q     <= type_d;
         num_q      <= num_d;
         seq_q      <= seq_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      type_d     = type_q;
      num_d      = num_q;
      seq_d      = seq_q;
      load_c     = 1'b0;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
            // A resolved branch outranks a hazard stall.
            if (mem_branch) begin
               state_d = ST_REDIRECT;
               pc_d    = mem_pc & 32'hFFFF_FFFC;
`ifdef FETCH_FLUSH_EN
               id_inst_d  = '0;
               id_valid_d = 1'b0;
               type_d     = '0;
`else
               load_c     = 1'b1;
`endif
            end else if (!stall) begin
               pc_d   = pc_q + XLEN'(4);
               load_c = 1'b1;
            end
         end
      endcase

      if (load_c) begin
         id_pc_d    = pc_q + XLEN'(4);
         id_inst_d  = if_inst;
         id_valid_d = 1'b1;
         type_d     = ins_class(if_inst);
         num_d      = seq_q;
         seq_d      = seq_q + TAG_W'(1);
      end
   end

   assign if_pc         = pc_q;
   assign id_pc         = id_pc_q;
   assign id_inst       = id_inst_q;
   assign id_valid      = id_valid_q;
   assign ID_ins_type   = type_q;
   assign ID_ins_number = num_q;

`ifdef FETCH_FLUSH_EN
   assign flush_id_ex  = mem_branch & rst_n;
   assign flush_ex_mem = mem_branch & rst_n;
`else
   assign flush_id_ex  = 1'b0;
   assign flush_ex_mem = 1'b0;
`endif

endmodule
